// File: rtl/perf_pkg.sv
// Shared types and channel map for the performance counter bank.
// Channel indices name the event strobes wired in from the CPU top level.
package perf_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        FROZEN = 1'b1
    } state_e;

    localparam int CH_INST = 0;
    localparam int CH_IHIT = 1;
    localparam int CH_IREQ = 2;
    localparam int CH_DHIT = 3;
    localparam int CH_DREQ = 4;
    localparam int CH_HALT = 5;

endpackage

// File: rtl/perf_counter.sv
// One event counter with a sticky overflow flag.
// At all-ones it either sticks (SATURATE=1) or wraps to zero; both set the flag.
module perf_counter #(
    parameter int CNT_W    = 32,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             hold_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can infer a latch.
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc_i && !hold_i) begin
            if (&cnt_q) begin
                ovf_d = 1'b1;
                cnt_d = SATURATE ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Event-statistics unit: NUM_CH event counters plus a cycle counter, a RUN/FROZEN
// FSM with halt and watchdog freeze, and a registered read port.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int  NUM_CH     = 6,
    parameter int  CNT_W      = 32,
    parameter int  MAX_CYCLES = 100000,
    parameter bit  SATURATE   = 1'b1,
    localparam int IDX_W      = $clog2(NUM_CH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NUM_CH-1:0] evt,
    input  logic              halt,
    input  logic              clear,
    input  logic              rd_req,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH:0]   ovf,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic              done,
    output logic              timeout
);

    // Compared in 64 bits so a watchdog limit beyond the counter range simply never fires.
    localparam logic [63:0] WD_LAST = 64'(MAX_CYCLES - 1);

    state_e           state_q, state_d;
    logic             timeout_q, timeout_d;
    logic             rd_valid_q;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;

    logic             count_en;
    logic             wd_hit;
    logic [NUM_CH:0]  inc_vec;
    logic [CNT_W-1:0] cnt [NUM_CH+1];

    assign count_en = en && (state_q == RUN);
    assign wd_hit   = (64'(cnt[NUM_CH]) == WD_LAST);
    assign inc_vec  = {1'b1, evt};

    for (genvar g = 0; g <= NUM_CH; g++) begin : g_cnt
        perf_counter #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_cnt (
            .clk    (clk),
            .rst_n  (rst_n),
            .inc_i  (inc_vec[g]),
            .hold_i (~count_en),
            .clr_i  (clear),
            .cnt_o  (cnt[g]),
            .ovf_o  (ovf[g])
        );
    end

    // Halt wins over a simultaneous watchdog hit; clear overrides any freeze.
    always_comb begin
        state_d   = state_q;
        timeout_d = timeout_q;
        if (clear) begin
            state_d   = RUN;
            timeout_d = 1'b0;
        end else if (count_en && (halt || wd_hit)) begin
            state_d   = FROZEN;
            timeout_d = !halt;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_req) begin
            rd_data_d = '0;
            for (int i = 0; i <= NUM_CH; i++) begin
                if (rd_idx == IDX_W'(i)) begin
                    rd_data_d = cnt[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            timeout_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            timeout_q  <= timeout_d;
            rd_valid_q <= rd_req;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign cycle_cnt = cnt[NUM_CH];
    assign done      = (state_q == FROZEN);
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench: a vector table plus a read scoreboard for the default
// configuration, and hand sequences for the small-width and short-watchdog variants.
module tb_perf_counter_bank;
    import perf_pkg::*;

    localparam int NUM_CH = 6;
    localparam int MAXC   = 100000;

    logic       clk = 1'b0;
    logic       rst_n, en, halt, clear, rd_req;
    logic [5:0] evt;
    logic [2:0] rd_idx;

    logic        a_rd_valid, a_done, a_timeout;
    logic [31:0] a_rd_data, a_cycle_cnt;
    logic [6:0]  a_ovf;
    logic        s_rd_valid, s_done, s_timeout;
    logic [3:0]  s_rd_data, s_cycle_cnt;
    logic [6:0]  s_ovf;
    logic        w_rd_valid, w_done, w_timeout;
    logic [3:0]  w_rd_data, w_cycle_cnt;
    logic [6:0]  w_ovf;
    logic        m_rd_valid, m_done, m_timeout;
    logic [31:0] m_rd_data, m_cycle_cnt;
    logic [6:0]  m_ovf;

    perf_counter_bank #(.NUM_CH(6), .CNT_W(32), .MAX_CYCLES(MAXC), .SATURATE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .evt(evt), .halt(halt), .clear(clear),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(a_rd_valid), .rd_data(a_rd_data),
        .ovf(a_ovf), .cycle_cnt(a_cycle_cnt), .done(a_done), .timeout(a_timeout));

    perf_counter_bank #(.NUM_CH(6), .CNT_W(4), .MAX_CYCLES(MAXC), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .evt(evt), .halt(halt), .clear(clear),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(s_rd_valid), .rd_data(s_rd_data),
        .ovf(s_ovf), .cycle_cnt(s_cycle_cnt), .done(s_done), .timeout(s_timeout));

    perf_counter_bank #(.NUM_CH(6), .CNT_W(4), .MAX_CYCLES(MAXC), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .evt(evt), .halt(halt), .clear(clear),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(w_rd_valid), .rd_data(w_rd_data),
        .ovf(w_ovf), .cycle_cnt(w_cycle_cnt), .done(w_done), .timeout(w_timeout));

    perf_counter_bank #(.NUM_CH(6), .CNT_W(32), .MAX_CYCLES(8), .SATURATE(1'b1)) dut_wd (
        .clk(clk), .rst_n(rst_n), .en(en), .evt(evt), .halt(halt), .clear(clear),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(m_rd_valid), .rd_data(m_rd_data),
        .ovf(m_ovf), .cycle_cnt(m_cycle_cnt), .done(m_done), .timeout(m_timeout));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model of the default instance and its read scoreboard.
    logic [31:0] m_cnt [7];
    bit          mdl_frozen;
    bit          mdl_timeout;
    logic [31:0] exp_q [$];

    task automatic model_zero();
        for (int i = 0; i < 7; i++) m_cnt[i] = '0;
        mdl_frozen  = 1'b0;
        mdl_timeout = 1'b0;
    endtask

    // Drives one cycle, advances the model for that edge, then checks the default instance.
    task automatic drive_cycle(input int r, input int e, input int ev, input int h,
                               input int c, input int rq, input int idx);
        bit wd;
        rst_n  = (r != 0);
        en     = (e != 0);
        evt    = 6'(ev);
        halt   = (h != 0);
        clear  = (c != 0);
        rd_req = (rq != 0);
        rd_idx = 3'(idx);
        if (r != 0 && rq != 0) exp_q.push_back((idx <= NUM_CH) ? m_cnt[idx] : 32'd0);
        if (r == 0) begin
            model_zero();
        end else if (c != 0) begin
            model_zero();
        end else if (e != 0 && !mdl_frozen) begin
            wd = (m_cnt[6] == 32'(MAXC - 1));
            for (int i = 0; i < 6; i++) if (evt[i]) m_cnt[i] = m_cnt[i] + 32'd1;
            m_cnt[6] = m_cnt[6] + 32'd1;
            if (h != 0 || wd) begin
                mdl_frozen  = 1'b1;
                mdl_timeout = (h == 0);
            end
        end
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            logic [31:0] exp_d;
            exp_d = exp_q.pop_front();
            check("sb_rd_valid", a_rd_valid, 1);
            check("sb_rd_data", a_rd_data, exp_d);
        end else begin
            check("sb_rd_idle", a_rd_valid, 0);
        end
        check("mdl_cycle_cnt", a_cycle_cnt, m_cnt[6]);
        check("mdl_done", a_done, mdl_frozen);
        check("mdl_timeout", a_timeout, mdl_timeout);
        check("mdl_ovf", a_ovf, 0);
    endtask

    typedef struct {
        logic        rst_n, en;
        logic [5:0]  evt;
        logic        halt, clear, rd_req;
        logic [2:0]  rd_idx;
        logic [31:0] exp_cyc;
        logic        exp_done, exp_to, exp_rdv;
        logic [31:0] exp_rdd;
    } vec_t;

    function automatic vec_t mk(input int r, input int e, input int ev, input int h,
                                input int c, input int rq, input int idx, input int cyc,
                                input int dn, input int to, input int rdv, input int rdd);
        vec_t v;
        v.rst_n    = (r != 0);
        v.en       = (e != 0);
        v.evt      = 6'(ev);
        v.halt     = (h != 0);
        v.clear    = (c != 0);
        v.rd_req   = (rq != 0);
        v.rd_idx   = 3'(idx);
        v.exp_cyc  = 32'(cyc);
        v.exp_done = (dn != 0);
        v.exp_to   = (to != 0);
        v.exp_rdv  = (rdv != 0);
        v.exp_rdd  = 32'(rdd);
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t tbl [$];
        int   ev01;
        ev01 = (1 << CH_INST) | (1 << CH_IHIT);

        // Count two channels for 11 cycles ending in halt, read back, clear while frozen.
        for (int i = 0; i < 10; i++) tbl.push_back(mk(1, 1, ev01, 0, 0, 0, 0, i + 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, ev01, 1, 0, 0, 0, 11, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, ev01, 0, 0, 1, CH_INST, 11, 1, 0, 1, 11));
        tbl.push_back(mk(1, 1, ev01, 0, 0, 1, CH_IHIT, 11, 1, 0, 1, 11));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 6, 11, 1, 0, 1, 11));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, CH_IREQ, 11, 1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 7, 11, 1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 6'h3f, 0, 1, 1, CH_INST, 0, 0, 0, 1, 11));
        // Channel 1 climbs to 5; a read alongside an event returns the pre-increment value.
        tbl.push_back(mk(1, 1, 2, 0, 0, 1, 1, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 2, 0, 0, 1, 1, 2, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 2, 0, 0, 0, 0, 3, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 2, 0, 0, 0, 0, 4, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 2, 0, 0, 0, 0, 5, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 2, 0, 0, 1, 1, 6, 0, 0, 1, 5));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1, 7, 0, 0, 1, 6));
        // en low holds everything even with all strobes active.
        for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 0, 6'h3f, 0, 0, 0, 0, 7, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 7, 0, 0, 1, 6));
        tbl.push_back(mk(1, 0, 6'h3f, 0, 0, 1, CH_HALT, 7, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 1, 6, 8, 0, 0, 1, 7));
        // Reset during a read request suppresses the response.
        tbl.push_back(mk(0, 1, 6'h3f, 1, 0, 1, 1, 0, 0, 0, 0, 0));

        rst_n = 1'b0; en = 1'b0; evt = '0; halt = 1'b0; clear = 1'b0;
        rd_req = 1'b0; rd_idx = '0;
        model_zero();

        drive_cycle(0, 0, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 0, 0);
        check("reset_rd_data", a_rd_data, 0);
        check("reset_cycle_cnt", a_cycle_cnt, 0);
        check("reset_done", a_done, 0);

        foreach (tbl[k]) begin
            drive_cycle(tbl[k].rst_n, tbl[k].en, tbl[k].evt, tbl[k].halt,
                        tbl[k].clear, tbl[k].rd_req, tbl[k].rd_idx);
            check($sformatf("vec%0d_cycle_cnt", k), a_cycle_cnt, tbl[k].exp_cyc);
            check($sformatf("vec%0d_done", k), a_done, tbl[k].exp_done);
            check($sformatf("vec%0d_timeout", k), a_timeout, tbl[k].exp_to);
            check($sformatf("vec%0d_rd_valid", k), a_rd_valid, tbl[k].exp_rdv);
            if (tbl[k].exp_rdv || !tbl[k].rst_n)
                check($sformatf("vec%0d_rd_data", k), a_rd_data, tbl[k].exp_rdd);
        end

        // Small counters: 20 strobes on channel 2, short watchdog freezes after 8 cycles.
        check("small_reset_cyc", s_cycle_cnt, 0);
        check("small_reset_ovf", s_ovf, 0);
        check("wd_reset_cyc", m_cycle_cnt, 0);
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1, 1, 1 << CH_IREQ, 0, 0, 0, 0);
            if (i == 6) begin
                check("wd_not_yet_done", m_done, 0);
                check("wd_cycle_7", m_cycle_cnt, 7);
            end
            if (i == 7) begin
                check("wd_done", m_done, 1);
                check("wd_timeout", m_timeout, 1);
                check("wd_cycle_8", m_cycle_cnt, 8);
            end
        end
        check("wd_cycle_held", m_cycle_cnt, 8);
        check("sat_cycle_cnt", s_cycle_cnt, 15);
        check("wrap_cycle_cnt", w_cycle_cnt, 4);
        drive_cycle(1, 0, 0, 0, 0, 1, CH_IREQ);
        check("sat_rd_valid", s_rd_valid, 1);
        check("sat_cnt2", s_rd_data, 15);
        check("wrap_cnt2", w_rd_data, 4);
        check("sat_ovf", s_ovf, 7'h44);
        check("wrap_ovf", w_ovf, 7'h44);

        drive_cycle(1, 1, 6'h3f, 0, 1, 0, 0);
        check("clear_sat_ovf", s_ovf, 0);
        check("clear_wrap_ovf", w_ovf, 0);
        check("clear_sat_cyc", s_cycle_cnt, 0);
        check("clear_wd_done", m_done, 0);
        check("clear_wd_timeout", m_timeout, 0);
        drive_cycle(1, 1, 0, 0, 0, 0, 0);
        check("resume_wd_cyc", m_cycle_cnt, 1);

        // Halt on the same edge as the watchdog hit: halt wins, no timeout.
        drive_cycle(0, 0, 0, 0, 0, 0, 0);
        check("rst_wd_cyc", m_cycle_cnt, 0);
        check("rst_wrap_cyc", w_cycle_cnt, 0);
        for (int i = 0; i < 7; i++) drive_cycle(1, 1, 0, 0, 0, 0, 0);
        check("wd2_cycle_7", m_cycle_cnt, 7);
        check("wd2_not_done", m_done, 0);
        drive_cycle(1, 1, 0, 1, 0, 0, 0);
        check("wd2_done", m_done, 1);
        check("wd2_timeout_halt_wins", m_timeout, 0);
        check("wd2_cycle_8", m_cycle_cnt, 8);
        drive_cycle(1, 1, 6'h3f, 0, 0, 0, 0);
        check("wd2_cycle_held", m_cycle_cnt, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
